// File: rtl/rom_page_loader.sv
// Loads a host-streamed system ROM image into SDRAM, one byte per two ce_ref slots,
// remapping 16 KB pages. Optional byte checksum output under ROM_PAGE_LOADER_CHECKSUM_EN.
module rom_page_loader (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce_ref,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        boot_wr,
  output logic [22:0] boot_a,
  output logic [1:0]  boot_bank,
  output logic [7:0]  boot_dout,
  output logic        rom_busy,
  output logic        done,
  output logic [2:0]  pages_done,
  output logic        overflow
`ifdef ROM_PAGE_LOADER_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);

  typedef enum logic [1:0] {StIdle, StArm, StWrite} state_e;

  state_e      state;
  logic        busy_q;
  logic        busy_rise;
  logic        busy_fall;
  logic [10:0] page;
  logic        page_mapped;
  logic [8:0]  page_base;
  logic [1:0]  page_bank;

  assign rom_busy  = ioctl_download && (ioctl_index == 8'd0);
  assign busy_rise = rom_busy && !busy_q;
  assign busy_fall = !rom_busy && busy_q;

  assign page        = ioctl_addr[24:14];
  assign page_mapped = (page < 11'd6);

  // Pages 0-2 and 3-5 share the same SDRAM layout, split across two banks.
  always_comb begin
    page_base = 9'h000;
    page_bank = 2'd0;
    case (page[2:0])
      3'd0: page_base = 9'h000;
      3'd1: page_base = 9'h100;
      3'd2: page_base = 9'h107;
      3'd3: begin page_base = 9'h000; page_bank = 2'd1; end
      3'd4: begin page_base = 9'h100; page_bank = 2'd1; end
      3'd5: begin page_base = 9'h107; page_bank = 2'd1; end
      default: begin page_base = 9'h000; page_bank = 2'd0; end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= StIdle;
      busy_q     <= 1'b0;
      ioctl_wait <= 1'b0;
      boot_wr    <= 1'b0;
      boot_a     <= '0;
      boot_bank  <= '0;
      boot_dout  <= '0;
      done       <= 1'b0;
      pages_done <= '0;
      overflow   <= 1'b0;
`ifdef ROM_PAGE_LOADER_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      busy_q <= rom_busy;
      if (busy_rise) begin
        done       <= 1'b0;
        pages_done <= '0;
        overflow   <= 1'b0;
`ifdef ROM_PAGE_LOADER_CHECKSUM_EN
        checksum   <= '0;
`endif
      end else if (busy_fall) begin
        done <= 1'b1;
      end

      case (state)
        StIdle: begin
          if (rom_busy && ioctl_wr) begin
            if (page_mapped) begin
              boot_dout  <= ioctl_dout;
              boot_a     <= {page_base, ioctl_addr[13:0]};
              boot_bank  <= page_bank;
              ioctl_wait <= 1'b1;
              state      <= StArm;
            end else begin
              overflow <= 1'b1;
            end
          end
        end
        StArm: begin
          if (ce_ref) begin
            boot_wr <= 1'b1;
            state   <= StWrite;
          end
        end
        StWrite: begin
          // Completion is independent of rom_busy so an in-flight byte always lands.
          if (ce_ref) begin
            boot_wr    <= 1'b0;
            ioctl_wait <= 1'b0;
            state      <= StIdle;
            if (boot_a[13:0] == 14'h3FFF && pages_done != 3'd6) begin
              pages_done <= pages_done + 3'd1;
            end
`ifdef ROM_PAGE_LOADER_CHECKSUM_EN
            checksum <= checksum + {8'h00, boot_dout};
`endif
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_page_loader.sv
// Directed, table-driven bench for rom_page_loader; tracks the checksum port when
// ROM_PAGE_LOADER_CHECKSUM_EN is defined.
module tb_rom_page_loader;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ce_ref;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wait;
  logic        boot_wr;
  logic [22:0] boot_a;
  logic [1:0]  boot_bank;
  logic [7:0]  boot_dout;
  logic        rom_busy;
  logic        done;
  logic [2:0]  pages_done;
  logic        overflow;
`ifdef ROM_PAGE_LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  logic [3:0] ce_cnt = 4'd0;
  int n_pass = 0;
  int n_total = 0;
  logic [15:0] sum_exp = '0;

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) ce_cnt <= ce_cnt + 4'd1;
  assign ce_ref = (ce_cnt == 4'hF);

  rom_page_loader dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ce_ref         (ce_ref),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .boot_wr        (boot_wr),
    .boot_a         (boot_a),
    .boot_bank      (boot_bank),
    .boot_dout      (boot_dout),
    .rom_busy       (rom_busy),
    .done           (done),
    .pages_done     (pages_done),
    .overflow       (overflow)
`ifdef ROM_PAGE_LOADER_CHECKSUM_EN
    ,
    .checksum       (checksum)
`endif
  );

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
    logic        mapped;
    logic [22:0] exp_a;
    logic [1:0]  exp_bank;
  } vec_t;

  vec_t vecs[8];
  vec_t pend[7];

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic send(input logic [24:0] addr, input logic [7:0] data);
    ioctl_addr = addr;
    ioctl_dout = data;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    sum_exp        = '0;
    tick();
    tick();
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    tick();
    tick();
  endtask

  // Waits out one accepted byte and checks the SDRAM request it produces.
  task automatic finish_byte(input string tag, input logic [22:0] ea, input logic [1:0] eb,
                             input logic [7:0] ed);
    int n;
    int hi;
    int wait_bad;
    n = 0;
    while (!boot_wr && n < 40) begin tick(); n++; end
    check({tag, " wr_rise"}, {31'd0, boot_wr}, 32'd1);
    check({tag, " rise_latency_le16"}, {31'd0, (n <= 16)}, 32'd1);
    check({tag, " boot_a"}, {9'd0, boot_a}, {9'd0, ea});
    check({tag, " boot_bank"}, {30'd0, boot_bank}, {30'd0, eb});
    check({tag, " boot_dout"}, {24'd0, boot_dout}, {24'd0, ed});
    hi = 0;
    wait_bad = 0;
    while (boot_wr && hi < 40) begin
      if (!ioctl_wait) wait_bad++;
      tick();
      hi++;
    end
    check({tag, " wr_width"}, hi, 32'd16);
    check({tag, " wait_held"}, wait_bad, 32'd0);
    check({tag, " wait_release"}, {31'd0, ioctl_wait}, 32'd0);
    sum_exp = sum_exp + {8'h00, ed};
  endtask

  task automatic do_vec(input string tag, input vec_t v);
    int bad;
    send(v.addr, v.data);
    if (v.mapped) begin
      check({tag, " wait_rise"}, {31'd0, ioctl_wait}, 32'd1);
      finish_byte(tag, v.exp_a, v.exp_bank, v.data);
    end else begin
      bad = 0;
      for (int i = 0; i < 40; i++) begin
        if (boot_wr || ioctl_wait) bad++;
        tick();
      end
      check({tag, " unmapped_quiet"}, bad, 32'd0);
      check({tag, " overflow"}, {31'd0, overflow}, 32'd1);
    end
  endtask

  initial begin
    int n;
    int bad;

    vecs[0] = '{25'h0000000, 8'hA5, 1'b1, 23'h000000, 2'd0};
    vecs[1] = '{25'h000C123, 8'h3C, 1'b1, 23'h000123, 2'd1};
    vecs[2] = '{25'h0014000, 8'h5A, 1'b1, 23'h41C000, 2'd1};
    vecs[3] = '{25'h0004001, 8'h11, 1'b1, 23'h400001, 2'd0};
    vecs[4] = '{25'h000BFFF, 8'h22, 1'b1, 23'h41FFFF, 2'd0};
    vecs[5] = '{25'h0010010, 8'h33, 1'b1, 23'h400010, 2'd1};
    vecs[6] = '{25'h0018000, 8'h77, 1'b0, 23'h000000, 2'd0};
    vecs[7] = '{25'h1FFFFFF, 8'h88, 1'b0, 23'h000000, 2'd0};

    // Last byte of each page, then a repeat of page 0 to hit saturation.
    pend[0] = '{25'h0003FFF, 8'h10, 1'b1, 23'h003FFF, 2'd0};
    pend[1] = '{25'h0007FFF, 8'h11, 1'b1, 23'h403FFF, 2'd0};
    pend[2] = '{25'h000BFFF, 8'h12, 1'b1, 23'h41FFFF, 2'd0};
    pend[3] = '{25'h000FFFF, 8'h13, 1'b1, 23'h003FFF, 2'd1};
    pend[4] = '{25'h0013FFF, 8'h14, 1'b1, 23'h403FFF, 2'd1};
    pend[5] = '{25'h0017FFF, 8'hF5, 1'b1, 23'h41FFFF, 2'd1};
    pend[6] = '{25'h0003FFF, 8'hE6, 1'b1, 23'h003FFF, 2'd0};

    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst ioctl_wait", {31'd0, ioctl_wait}, 32'd0);
    check("rst boot_wr", {31'd0, boot_wr}, 32'd0);
    check("rst boot_a", {9'd0, boot_a}, 32'd0);
    check("rst boot_bank", {30'd0, boot_bank}, 32'd0);
    check("rst boot_dout", {24'd0, boot_dout}, 32'd0);
    check("rst flags", {27'd0, done, pages_done, overflow}, 32'd0);

    // Download 1: mapping table plus unmapped bytes.
    start_dl(8'd0);
    check("dl1 rom_busy", {31'd0, rom_busy}, 32'd1);
    for (int i = 0; i < 8; i++) do_vec($sformatf("vec%0d", i), vecs[i]);
    check("dl1 pages_done", {29'd0, pages_done}, 32'd1);

    // Host violation: second ioctl_wr while a byte is pending must be ignored.
    send(25'h0000100, 8'h66);
    send(25'h0004000, 8'h99);
    finish_byte("viol", 23'h000100, 2'd0, 8'h66);
`ifdef ROM_PAGE_LOADER_CHECKSUM_EN
    check("dl1 checksum", {16'd0, checksum}, {16'd0, sum_exp});
`endif
    end_dl();
    check("dl1 done", {31'd0, done}, 32'd1);
    check("dl1 overflow_sticky", {31'd0, overflow}, 32'd1);

    // Download 2: one byte per page end.
    start_dl(8'd0);
    check("dl2 start clears", {27'd0, done, pages_done, overflow}, 32'd0);
    for (int i = 0; i < 6; i++) do_vec($sformatf("pend%0d", i), pend[i]);
    check("dl2 pages_done6", {29'd0, pages_done}, 32'd6);
    do_vec("pend_sat", pend[6]);
    check("dl2 pages_done_sat", {29'd0, pages_done}, 32'd6);
`ifdef ROM_PAGE_LOADER_CHECKSUM_EN
    check("dl2 checksum", {16'd0, checksum}, {16'd0, sum_exp});
`endif
    end_dl();
    check("dl2 done", {31'd0, done}, 32'd1);
    check("dl2 overflow", {31'd0, overflow}, 32'd0);
    check("dl2 pages_after", {29'd0, pages_done}, 32'd6);

    // Non-ROM index: nothing reaches SDRAM.
    start_dl(8'd1);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      ioctl_addr = 25'(i);
      ioctl_dout = 8'(i);
      ioctl_wr   = 1'b1;
      tick();
      if (boot_wr || ioctl_wait || rom_busy) bad++;
      ioctl_wr = 1'b0;
      tick();
      if (boot_wr || ioctl_wait || rom_busy) bad++;
    end
    check("idx1 quiet", bad, 32'd0);
    end_dl();
    check("idx1 done_kept", {31'd0, done}, 32'd1);

    // Reset three cycles into a write.
    start_dl(8'd0);
    do_vec("rst_pre_page", pend[0]);
    do_vec("rst_pre_ovf", vecs[6]);
    check("rst_pre flags", {28'd0, pages_done, overflow}, {28'd0, 3'd1, 1'b1});
    send(25'h0000200, 8'h55);
    n = 0;
    while (!boot_wr && n < 40) begin tick(); n++; end
    check("rst wr_rise", {31'd0, boot_wr}, 32'd1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid boot_wr", {31'd0, boot_wr}, 32'd0);
    check("rst_mid ioctl_wait", {31'd0, ioctl_wait}, 32'd0);
    check("rst_mid flags", {27'd0, done, pages_done, overflow}, 32'd0);
`ifdef ROM_PAGE_LOADER_CHECKSUM_EN
    check("rst_mid checksum", {16'd0, checksum}, 32'd0);
`endif
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (boot_wr || ioctl_wait) bad++;
      tick();
    end
    check("rst_mid no_retry", bad, 32'd0);
    do_vec("post_rst", vecs[1]);
    end_dl();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
